// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared types and widths for the PLL reset/lock sequencer.
package pll_seq_pkg;

    // Sequencer states. FAULT only has behaviour when PLL_SEQ_TIMEOUT_EN is defined.
    typedef enum logic [2:0] {
        PLLRST  = 3'd0,
        WAIT    = 3'd1,
        STABLE  = 3'd2,
        RUN     = 3'd3,
        CORERST = 3'd4,
        FAULT   = 3'd5
    } pll_seq_state_t;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;
    localparam logic [LOSS_W-1:0] LOSS_MAX = 8'd255;

    // Larger of two cycle counts; used to size the shared counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync.sv
// sync_2ff: two-flop single-bit synchroniser, synchronously reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops; the first may go metastable, the second resolves it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives the PLL reset, qualifies its lock and holds the
// core in reset until lock has been stable long enough. Handles lock loss and
// soft-reset requests from the core.
// Optional macro PLL_SEQ_TIMEOUT_EN: enables lock timeout, PLL reset retries
// and the sticky FAULT state. Without it WAIT waits forever and fault /
// retry_cnt are tied to 0.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 7,
    parameter int CORE_RST_CYCLES     = 64
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               locked,
    input  logic               soft_reset,
    output logic               pll_rst,
    output logic               core_reset,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  loss_cnt,
    output pll_seq_state_t     dbg_state
);

    // One counter is shared by every timed state, so it is sized for the
    // longest interval actually in use in this build.
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam int CNT_MAX = max_int(max_int(RST_CYCLES, LOCK_STABLE_CYCLES),
                                     max_int(CORE_RST_CYCLES, LOCK_TIMEOUT_CYCLES));
`else
    localparam int CNT_MAX = max_int(max_int(RST_CYCLES, LOCK_STABLE_CYCLES),
                                     CORE_RST_CYCLES);
    // Timeout settings have no meaning without the timeout logic.
    localparam int unused_timeout_cfg = LOCK_TIMEOUT_CYCLES + MAX_RETRIES;
`endif
    localparam int CNT_W = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_RST_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [CNT_W-1:0]   TO_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRIES);
`endif

    pll_seq_state_t      state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [LOSS_W-1:0]   loss_q, loss_d;
    logic                lock_s;
`ifdef PLL_SEQ_TIMEOUT_EN
    logic [RETRY_W-1:0]  retry_q, retry_d;
    logic                fault_q;
`endif

    // locked comes from the PLL, asynchronous to refclk.
    sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lock_s)
    );

    // Next-state logic. Within a state, lock loss beats timeout, which beats
    // soft_reset, which beats the counter reaching its terminal value.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        loss_d  = loss_q;
`ifdef PLL_SEQ_TIMEOUT_EN
        retry_d = retry_q;
`endif
        case (state_q)
            PLLRST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end
            end
            WAIT: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIM) begin
                        state_d = FAULT;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = PLLRST;
                    end
                end
`else
                else begin
                    // Nothing to time out; keep the counter parked.
                    cnt_d = '0;
                end
`endif
            end
            STABLE: begin
                if (!lock_s) begin
                    // Lock dropped before qualifying: start over, fresh timeout.
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    // PLL relocks on its own, so it is not reset here.
                    state_d = WAIT;
                    if (loss_q != LOSS_MAX) begin
                        loss_d = loss_q + 1'b1;
                    end
                end else if (soft_reset) begin
                    state_d = CORERST;
                end
            end
            CORERST: begin
                if (!lock_s) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                end else if (soft_reset) begin
                    // A held request stretches the core reset.
                    cnt_d = '0;
                end else if (cnt_q == CORE_LAST) begin
                    // Re-qualify lock before releasing the core again.
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
`ifdef PLL_SEQ_TIMEOUT_EN
            FAULT: begin
                cnt_d = '0;
            end
`endif
            default: begin
                state_d = PLLRST;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so
    // they change on the same edge as the state.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= PLLRST;
            cnt_q      <= '0;
            loss_q     <= '0;
            pll_rst    <= 1'b1;
            core_reset <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            loss_q     <= loss_d;
            pll_rst    <= (state_d == PLLRST);
            core_reset <= (state_d != RUN);
            ready      <= (state_d == RUN);
        end
    end

`ifdef PLL_SEQ_TIMEOUT_EN
    // Retry count and the sticky fault flag; only rst clears them.
    always_ff @(posedge refclk) begin
        if (rst) begin
            retry_q <= '0;
            fault_q <= 1'b0;
        end else begin
            retry_q <= retry_d;
            fault_q <= (state_d == FAULT);
        end
    end

    assign retry_cnt = retry_q;
    assign fault     = fault_q;
`else
    assign retry_cnt = '0;
    assign fault     = 1'b0;
`endif

    assign loss_cnt  = loss_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario tasks with timing derived from the lock and
// reset rules, plus a randomized run checked against a behavioural model.
// Build with or without PLL_SEQ_TIMEOUT_EN; the bench adapts.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;
    import pll_seq_pkg::*;

    localparam int RST_C = 4;
    localparam int LSC   = 8;
    localparam int LTO   = 20;
    localparam int MR    = 2;
    localparam int CRC   = 4;
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic refclk = 1'b0;
    logic rst = 1'b1;
    logic locked = 1'b0;
    logic soft_reset = 1'b0;
    logic pll_rst, core_reset, ready, fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    pll_seq_state_t dbg_state;

    always #10 refclk = ~refclk;

    pll_reset_sequencer #(
        .RST_CYCLES(RST_C), .LOCK_STABLE_CYCLES(LSC), .LOCK_TIMEOUT_CYCLES(LTO),
        .MAX_RETRIES(MR), .CORE_RST_CYCLES(CRC)
    ) dut (
        .refclk(refclk), .rst(rst), .locked(locked), .soft_reset(soft_reset),
        .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready), .fault(fault),
        .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // ---------------- behavioural model ----------------
    // Mode plus the cycle it was entered; timed exits use elapsed cycles.
    localparam int M_PLLRST = 0, M_WAIT = 1, M_STABLE = 2, M_RUN = 3, M_CORERST = 4, M_FAULT = 5;
    int m_mode = M_PLLRST;
    int m_enter = 0;
    int m_retry = 0;
    int m_loss = 0;
    bit m_s1 = 1'b0, m_s2 = 1'b0;
    bit sb_on = 1'b0;
    logic [15:0] exp_q[$];

    task automatic go(input int mode);
        m_mode  = mode;
        m_enter = cyc + 1;
    endtask

    task automatic model_tick();
        bit ls;
        int age;
        ls   = m_s2;
        m_s2 = m_s1;
        m_s1 = locked;
        age  = cyc - m_enter;
        if (rst) begin
            go(M_PLLRST);
            m_s1 = 1'b0; m_s2 = 1'b0; m_retry = 0; m_loss = 0;
            return;
        end
        case (m_mode)
            M_PLLRST: if (age == RST_C - 1) go(M_WAIT);
            M_WAIT: begin
                if (ls) go(M_STABLE);
                else if (TO_EN && age == LTO - 1) begin
                    if (m_retry == MR) go(M_FAULT);
                    else begin m_retry++; go(M_PLLRST); end
                end
            end
            M_STABLE: begin
                if (!ls) go(M_WAIT);
                else if (age == LSC - 1) go(M_RUN);
            end
            M_RUN: begin
                if (!ls) begin go(M_WAIT); if (m_loss < 255) m_loss++; end
                else if (soft_reset) go(M_CORERST);
            end
            M_CORERST: begin
                if (!ls) go(M_WAIT);
                else if (soft_reset) go(M_CORERST);
                else if (age == CRC - 1) go(M_STABLE);
            end
            default: ;
        endcase
    endtask

    function automatic logic [15:0] model_out();
        return {m_mode == M_PLLRST, m_mode != M_RUN, m_mode == M_RUN, m_mode == M_FAULT,
                4'(m_retry), 8'(m_loss)};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change at the negedge; the model and DUT both see them at the posedge.
    task automatic tick();
        @(posedge refclk);
        model_tick();
        cyc++;
        if (sb_on) exp_q.push_back(model_out());
        @(negedge refclk);
    endtask

    // Leaves the bench in cycle 0: rst has just been released.
    task automatic do_reset();
        rst = 1'b1; locked = 1'b0; soft_reset = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            locked = 1'($urandom_range(0, 1));
            soft_reset = 1'($urandom_range(0, 1));
            tick();
        end
        n_checks++; if ({pll_rst, core_reset, ready, fault} !== 4'b1100)
            $display("FAIL reset_flags: got %b want 1100", {pll_rst, core_reset, ready, fault}); else n_pass++;
        n_checks++; if (retry_cnt !== 4'd0) $display("FAIL reset_retry: got %0d want 0", retry_cnt); else n_pass++;
        n_checks++; if (loss_cnt !== 8'd0) $display("FAIL reset_loss: got %0d want 0", loss_cnt); else n_pass++;
        n_checks++; if (dbg_state !== PLLRST) $display("FAIL reset_state: got %0d want %0d", dbg_state, PLLRST); else n_pass++;
        locked = 1'b0; soft_reset = 1'b0;
    endtask

    // locked rises in cycle 10: pll_rst high cycles 0..3, release at cycle 21.
    task automatic test_power_up();
        do_reset();
        for (int k = 0; k <= 22; k++) begin
            if (k == 10) locked = 1'b1;
            n_checks++; if (pll_rst !== (k < RST_C)) $display("FAIL pu_pll_rst c%0d: got %b want %b", k, pll_rst, k < RST_C); else n_pass++;
            n_checks++; if (core_reset !== (k < 21)) $display("FAIL pu_core_reset c%0d: got %b want %b", k, core_reset, k < 21); else n_pass++;
            n_checks++; if (ready !== (k >= 21)) $display("FAIL pu_ready c%0d: got %b want %b", k, ready, k >= 21); else n_pass++;
            tick();
        end
    endtask

    // 1-cycle drop at cycle 15 during STABLE; last rise at 16 gives release at 27.
    task automatic test_stable_glitch();
        do_reset();
        for (int k = 0; k <= 28; k++) begin
            locked = ((k >= 10) && (k < 15)) || (k >= 16);
            n_checks++; if (core_reset !== (k < 27)) $display("FAIL sg_core_reset c%0d: got %b want %b", k, core_reset, k < 27); else n_pass++;
            n_checks++; if (ready !== (k >= 27)) $display("FAIL sg_ready c%0d: got %b want %b", k, ready, k >= 27); else n_pass++;
            tick();
        end
        n_checks++; if (loss_cnt !== 8'd0) $display("FAIL sg_loss: got %0d want 0", loss_cnt); else n_pass++;
    endtask

    // From RUN: locked low 3 cycles; core reset from drop+3, release at drop+14.
    task automatic test_lock_loss();
        for (int j = 0; j <= 16; j++) begin
            logic exp_cr;
            exp_cr = (j >= 3) && (j < 14);
            locked = (j >= 3);
            n_checks++; if (core_reset !== exp_cr) $display("FAIL ll_core_reset j%0d: got %b want %b", j, core_reset, exp_cr); else n_pass++;
            n_checks++; if (ready !== !exp_cr) $display("FAIL ll_ready j%0d: got %b want %b", j, ready, !exp_cr); else n_pass++;
            n_checks++; if (pll_rst !== 1'b0) $display("FAIL ll_pll_rst j%0d: got %b want 0", j, pll_rst); else n_pass++;
            n_checks++; if (loss_cnt !== ((j >= 3) ? 8'd1 : 8'd0))
                $display("FAIL ll_loss j%0d: got %0d want %0d", j, loss_cnt, (j >= 3) ? 1 : 0); else n_pass++;
            tick();
        end
    endtask

    // 1-cycle soft_reset in RUN: core_reset for CRC + LSC cycles from the next cycle.
    task automatic test_soft_reset();
        for (int j = 0; j <= 15; j++) begin
            logic exp_cr;
            exp_cr = (j >= 1) && (j <= CRC + LSC);
            soft_reset = (j == 0);
            n_checks++; if (core_reset !== exp_cr) $display("FAIL sr_core_reset j%0d: got %b want %b", j, core_reset, exp_cr); else n_pass++;
            n_checks++; if (pll_rst !== 1'b0) $display("FAIL sr_pll_rst j%0d: got %b want 0", j, pll_rst); else n_pass++;
            tick();
        end
        soft_reset = 1'b0;
        n_checks++; if (loss_cnt !== 8'd1) $display("FAIL sr_loss: got %0d want 1", loss_cnt); else n_pass++;
    endtask

`ifdef PLL_SEQ_TIMEOUT_EN
    // No lock: each round is RST_C + LTO cycles; third timeout lands in FAULT.
    task automatic test_timeout();
        int round;
        do_reset();
        for (int k = 0; k <= 75; k++) begin
            logic exp_pr;
            round  = k / (RST_C + LTO);
            exp_pr = (round <= MR) && ((k % (RST_C + LTO)) < RST_C);
            n_checks++; if (retry_cnt !== 4'((round > MR) ? MR : round))
                $display("FAIL to_retry c%0d: got %0d want %0d", k, retry_cnt, (round > MR) ? MR : round); else n_pass++;
            n_checks++; if (fault !== (round > MR)) $display("FAIL to_fault c%0d: got %b want %b", k, fault, round > MR); else n_pass++;
            n_checks++; if (pll_rst !== exp_pr) $display("FAIL to_pll_rst c%0d: got %b want %b", k, pll_rst, exp_pr); else n_pass++;
            n_checks++; if (core_reset !== 1'b1) $display("FAIL to_core_reset c%0d: got %b want 1", k, core_reset); else n_pass++;
            tick();
        end
        rst = 1'b1;
        tick();
        n_checks++; if ({fault, retry_cnt} !== 5'd0) $display("FAIL to_clear: got fault=%b retry=%0d want 0/0", fault, retry_cnt); else n_pass++;
        rst = 1'b0;
    endtask
`else
    // No lock for 1000 cycles: stays in WAIT, one PLL reset pulse only.
    task automatic test_no_timeout();
        int high_cycles = 0, rises = 0, bad_out = 0;
        logic prev = 1'b1;
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            if (pll_rst === 1'b1) high_cycles++;
            if (pll_rst === 1'b1 && prev === 1'b0) rises++;
            if (ready !== 1'b0 || core_reset !== 1'b1 || fault !== 1'b0 || retry_cnt !== 4'd0) bad_out++;
            prev = pll_rst;
            tick();
        end
        n_checks++; if (high_cycles != RST_C) $display("FAIL nt_pll_high: got %0d want %0d", high_cycles, RST_C); else n_pass++;
        n_checks++; if (rises != 0) $display("FAIL nt_pll_rises: got %0d want 0", rises); else n_pass++;
        n_checks++; if (bad_out != 0) $display("FAIL nt_outputs: got %0d bad cycles want 0", bad_out); else n_pass++;
        n_checks++; if (dbg_state !== WAIT) $display("FAIL nt_state: got %0d want %0d", dbg_state, WAIT); else n_pass++;
    endtask
`endif

    // 258 lock losses in RUN; loss_cnt must stop at 255.
    task automatic test_loss_saturation();
        do_reset();
        locked = 1'b1;
        for (int i = 0; i < 50 && ready !== 1'b1; i++) tick();
        n_checks++; if (ready !== 1'b1) $display("FAIL ls_first_ready: got %b want 1", ready); else n_pass++;
        for (int i = 0; i < 258; i++) begin
            for (int j = 0; j < 17; j++) begin
                locked = (j >= 3);
                tick();
            end
            n_checks++; if (loss_cnt !== 8'((i + 1 > 255) ? 255 : i + 1))
                $display("FAIL ls_loss i%0d: got %0d want %0d", i, loss_cnt, (i + 1 > 255) ? 255 : i + 1); else n_pass++;
            n_checks++; if (ready !== 1'b1) $display("FAIL ls_ready i%0d: got %b want 1", i, ready); else n_pass++;
        end
    endtask

    // Random lock runs, glitches, soft resets and occasional rst vs the model.
    task automatic test_random();
        int lock_run = 0, soft_run = 0;
        logic [15:0] exp;
        do_reset();
        exp_q.delete();
        sb_on = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (lock_run == 0) begin
                locked = ~locked;
                if (locked) lock_run = $urandom_range(5, 120);
                else lock_run = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 90) : $urandom_range(1, 6);
            end
            lock_run--;
            if (soft_run > 0) soft_run--;
            else if ($urandom_range(0, 29) == 0) soft_run = $urandom_range(1, 6);
            soft_reset = (soft_run > 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
            exp = exp_q.pop_front();
            n_checks++;
            if ({pll_rst, core_reset, ready, fault, retry_cnt, loss_cnt} !== exp)
                $display("FAIL rnd c%0d: got %h want %h", k,
                         {pll_rst, core_reset, ready, fault, retry_cnt, loss_cnt}, exp);
            else n_pass++;
        end
        sb_on = 1'b0;
        rst = 1'b0; soft_reset = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_power_up();
        test_stable_glitch();
        test_lock_loss();
        test_soft_reset();
`ifdef PLL_SEQ_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_loss_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
